sprite_layer: RTL and testbench
===============================

SPRITE_LAYER -- requirements
Module: sprite_layer

Interface
REQ-001 NUM_SPRITES, 2, number of sprite channels (1..4); lower index wins priority.
REQ-002 SPR_LOG2, 5, sprite edge is 2**SPR_LOG2 pixels (square, source pixels).
REQ-003 SCALE_SHIFT, 0, each source pixel drawn as a (2**SCALE_SHIFT) x (2**SCALE_SHIFT) block (0..2).
REQ-004 TRANSP_IDX, 0, 4-bit ROM index treated as transparent.
REQ-005 BG_RGB, 12'h000, background colour {r,g,b} where no opaque sprite pixel.
REQ-006 V_ACTIVE, 480, first non-visible line; shadow commit line.
REQ-007 vga_clk  in  1  pixel clock; all state on rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 DrawX, DrawY  in  10 each  current pixel coordinate.
REQ-010 blank  in  1  high = visible pixel (active video).
REQ-011 load_valid / load_ready  in / out  1 / 1  position-update handshake.
REQ-012 load_id  in  2  target sprite; load_x, load_y  in  10 each  new top-left; load_en  in  1  new enable.
REQ-013 rom_addr  out  NUM_SPRITES x 2*SPR_LOG2  per-sprite ROM address; rom_q  in  NUM_SPRITES x 4  per-sprite ROM data, valid exactly one cycle after rom_addr.
REQ-014 red, green, blue  out  4 each  registered pixel colour.

Function
REQ-015 Each sprite has active regs (x, y, en) and shadow regs (x, y, en, pending).
REQ-016 load_valid && load_ready writes shadow of load_id and sets its pending; load_id >= NUM_SPRITES is accepted and discarded.
REQ-017 A later load to the same id before commit overwrites the shadow; only the last value commits.
REQ-018 Commit cycle = cycle where DrawX==0 and DrawY==V_ACTIVE: every pending shadow copies to active, pending clears.
REQ-019 load_ready is low only in the commit cycle; a load presented then stalls one cycle and lands in the next frame's shadow.
REQ-020 Stage 0: per sprite, hit = en && DrawX-x and DrawY-y (10-bit unsigned, no wrap) both < 2**(SPR_LOG2+SCALE_SHIFT); rom_addr = {(DrawY-y)>>SCALE_SHIFT, (DrawX-x)>>SCALE_SHIFT} truncated to SPR_LOG2 bits each; registered with hit and blank.
REQ-021 Stage 1: rom_q arrives; opaque = hit && rom_q != TRANSP_IDX.
REQ-022 Stage 2: lowest-index opaque sprite's index goes through sprite_palette; none -> BG_RGB; blank low -> 0.
REQ-023 Latency DrawX/DrawY/blank in to red/green/blue out is exactly 3 cycles; blank is pipelined alongside data.
REQ-024 Sprite partially off-screen right/bottom: only visible part drawn; x,y beyond 639/479 draws nothing, no wrap to left/top.
REQ-025 Rows within one frame always use one consistent active set (no tearing).

Reset
REQ-026 reset_n low asynchronously clears: active and shadow en, pending, x, y to 0; pipeline regs to 0; red/green/blue to 0; load_ready to 1.
REQ-027 Reset mid-frame: outputs 0 from assertion; after release first valid colour appears 3 cycles after first sampled pixel.
REQ-028 A load in the same cycle reset_n deasserts is accepted.

Structure
REQ-029 Shared package sprite_pkg: rgb12_t, sprite_pos_t {x,y,en}, SPR_IDX_W=4, H_ACTIVE=640.
REQ-030 One sub-module: sprite_palette (combinational 16-entry index -> 12-bit RGB), one instance at stage 2.
REQ-031 ROMs are external; sprite_layer drives addresses only.

Verification
REQ-032 Reset, sprite0 load (100,50,en=1), run to commit; pixel (100,50) index 3 -> palette[3] appears 3 cycles after DrawX=100,DrawY=50; pixel (99,50) -> BG_RGB.
REQ-033 Sprites 0 and 1 both at (200,200), both opaque -> sprite0 colour; sprite0 index = TRANSP_IDX -> sprite1 colour.
REQ-034 SCALE_SHIFT=1, sprite at (0,0): rom_addr constant across DrawX 0..1, increments at 2; no hit at DrawX=64.
REQ-035 Load x=10 mid-frame at DrawY=100 then x=20 before commit: remainder of frame uses old x; next frame x=20; load_ready low only at (0,480).
REQ-036 Sprite at x=620: columns 620..639 drawn, none at DrawX 0..11; blank low anywhere -> rgb 0.
REQ-037 reset_n pulse at DrawY=240 -> outputs 0 immediately, sprites disabled until reloaded and committed.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite layer.
//   rgb12_t      : {r,g,b} 4 bits each
//   sprite_pos_t : sprite top-left position plus enable
//   SPR_IDX_W    : width of a ROM colour index
//   H_ACTIVE     : first non-visible column
package sprite_pkg;
  localparam int SPR_IDX_W = 4;
  localparam int H_ACTIVE  = 640;

  typedef logic [11:0] rgb12_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
  } sprite_pos_t;
endpackage

// File: rtl/sprite_layer_if.sv
// Position-update handshake for the sprite layer.
//   master : drives load_valid/load_id/load_x/load_y/load_en, sees load_ready
//   slave  : the sprite layer, drives load_ready
interface sprite_layer_if;
  logic       load_valid;
  logic       load_ready;
  logic [1:0] load_id;
  logic [9:0] load_x;
  logic [9:0] load_y;
  logic       load_en;

  modport master (output load_valid, load_id, load_x, load_y, load_en,
                  input  load_ready);
  modport slave  (input  load_valid, load_id, load_x, load_y, load_en,
                  output load_ready);
endinterface

// File: rtl/sprite_palette.sv
// Combinational 16-entry colour lookup: ROM index -> 12-bit RGB.
//   idx : colour index
//   rgb : {r,g,b}
module sprite_palette
  import sprite_pkg::*;
(
  input  logic [SPR_IDX_W-1:0] idx,
  output rgb12_t               rgb
);
  always_comb begin
    rgb = 12'h000;
    case (idx)
      4'h0: rgb = 12'h000;
      4'h1: rgb = 12'hF00;
      4'h2: rgb = 12'h0F0;
      4'h3: rgb = 12'h00F;
      4'h4: rgb = 12'hFF0;
      4'h5: rgb = 12'h0FF;
      4'h6: rgb = 12'hF0F;
      4'h7: rgb = 12'hFFF;
      4'h8: rgb = 12'h888;
      4'h9: rgb = 12'h800;
      4'hA: rgb = 12'h080;
      4'hB: rgb = 12'h008;
      4'hC: rgb = 12'h880;
      4'hD: rgb = 12'h088;
      4'hE: rgb = 12'h808;
      4'hF: rgb = 12'h444;
      default: rgb = 12'h000;
    endcase
  end
endmodule

// File: rtl/sprite_layer.sv
// Multi-sprite overlay with double-buffered positions.
//   vga_clk, reset_n : pixel clock, async active-low reset
//   DrawX, DrawY     : current pixel coordinate
//   blank            : high on visible pixels
//   ld               : position-update handshake (slave side)
//   rom_addr, rom_q  : per-sprite external ROM address / data (data one cycle later)
//   red/green/blue   : registered pixel colour, 3 cycles after DrawX/DrawY/blank
// Pipeline: stage 0 hit test + address, stage 1 ROM data + opacity,
// stage 2 priority select + palette into the output registers.
module sprite_layer
  import sprite_pkg::*;
#(
  parameter int          NUM_SPRITES = 2,
  parameter int          SPR_LOG2    = 5,
  parameter int          SCALE_SHIFT = 0,
  parameter logic [3:0]  TRANSP_IDX  = 4'd0,
  parameter rgb12_t      BG_RGB      = 12'h000,
  parameter int          V_ACTIVE    = 480
)(
  input  logic                                       vga_clk,
  input  logic                                       reset_n,
  input  logic [9:0]                                 DrawX,
  input  logic [9:0]                                 DrawY,
  input  logic                                       blank,
  sprite_layer_if.slave                              ld,
  output logic [NUM_SPRITES-1:0][2*SPR_LOG2-1:0]     rom_addr,
  input  logic [NUM_SPRITES-1:0][SPR_IDX_W-1:0]      rom_q,
  output logic [3:0]                                 red,
  output logic [3:0]                                 green,
  output logic [3:0]                                 blue
);
  localparam int          AW    = 2*SPR_LOG2;
  localparam int          PIPE  = 1;
  localparam logic [10:0] EDGE  = 11'(1 << (SPR_LOG2+SCALE_SHIFT));

  sprite_pos_t [NUM_SPRITES-1:0]         act_q, act_d, shd_q, shd_d;
  logic [NUM_SPRITES-1:0]                pend_q, pend_d;
  logic [NUM_SPRITES-1:0][AW-1:0]        addr_q, addr_d;
  logic [NUM_SPRITES-1:0]                hit0_q, hit0_d, hit1_q, hit1_d;
  logic [PIPE:0]                         vld_pipe_q, vld_pipe_d;
  rgb12_t                                rgb_q, rgb_d;

  logic                                  commit, accept;
  logic [SPR_IDX_W-1:0]                  sel_idx;
  logic                                  sel_any;
  rgb12_t                                pal_rgb;

  // Shadows swap into the active set once per frame, on the first
  // invisible line, so every visible row sees the same positions.
  assign commit        = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));
  assign ld.load_ready = ~reset_n | ~commit;
  assign accept        = ld.load_valid & ld.load_ready;

  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    if (commit) begin
      for (int s = 0; s < NUM_SPRITES; s++) begin
        if (pend_q[s]) begin
          act_d[s]  = shd_q[s];
          pend_d[s] = 1'b0;
        end
      end
    end
    // Ids past NUM_SPRITES match nothing and fall away silently.
    if (accept) begin
      for (int s = 0; s < NUM_SPRITES; s++) begin
        if (int'(ld.load_id) == s) begin
          shd_d[s].x  = ld.load_x;
          shd_d[s].y  = ld.load_y;
          shd_d[s].en = ld.load_en;
          pend_d[s]   = 1'b1;
        end
      end
    end
  end

  // Stage 0: offsets are only meaningful when the pixel is at or past the
  // top-left corner; the explicit >= keeps a wrapped difference from hitting.
  for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_spr
    logic [9:0] dx, dy;
    assign dx = DrawX - act_q[s].x;
    assign dy = DrawY - act_q[s].y;
    assign hit0_d[s] = act_q[s].en
                     && (DrawX >= act_q[s].x) && (DrawY >= act_q[s].y)
                     && ({1'b0, dx} < EDGE) && ({1'b0, dy} < EDGE)
                     && (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
    assign addr_d[s] = {dy[SCALE_SHIFT +: SPR_LOG2], dx[SCALE_SHIFT +: SPR_LOG2]};
  end

  assign hit1_d     = hit0_q;
  assign vld_pipe_d = {vld_pipe_q[PIPE-1:0], blank};

  // Stage 1/2: walk from highest index down so the lowest opaque one wins.
  always_comb begin
    sel_idx = '0;
    sel_any = 1'b0;
    for (int s = NUM_SPRITES-1; s >= 0; s--) begin
      if (hit1_q[s] && (rom_q[s] != TRANSP_IDX)) begin
        sel_idx = rom_q[s];
        sel_any = 1'b1;
      end
    end
  end

  sprite_palette u_pal (
    .idx (sel_idx),
    .rgb (pal_rgb)
  );

  always_comb begin
    rgb_d = 12'h000;
    if (vld_pipe_q[PIPE]) rgb_d = sel_any ? pal_rgb : BG_RGB;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      act_q      <= '0;
      shd_q      <= '0;
      pend_q     <= '0;
      addr_q     <= '0;
      hit0_q     <= '0;
      hit1_q     <= '0;
      vld_pipe_q <= '0;
      rgb_q      <= '0;
    end else begin
      act_q      <= act_d;
      shd_q      <= shd_d;
      pend_q     <= pend_d;
      addr_q     <= addr_d;
      hit0_q     <= hit0_d;
      hit1_q     <= hit1_d;
      vld_pipe_q <= vld_pipe_d;
      rgb_q      <= rgb_d;
    end
  end

  assign rom_addr = addr_q;
  assign red      = rgb_q[11:8];
  assign green    = rgb_q[7:4];
  assign blue     = rgb_q[3:0];
endmodule

// File: tb/tb_sprite_layer.sv
// Scoreboard bench for sprite_layer: a default 2-sprite instance with a
// bench ROM, and a 1-sprite SCALE_SHIFT=1 instance fed a constant opaque index.
module tb_sprite_layer;
  import sprite_pkg::*;

  localparam int     NS = 2;
  localparam rgb12_t BG = 12'h123;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] DrawX = '0, DrawY = '0;
  logic       blank = 1'b0;

  sprite_layer_if bus ();
  sprite_layer_if bus2 ();

  logic [NS-1:0][9:0] rom_addr;
  logic [NS-1:0][3:0] rom_q;
  logic [3:0]         red, green, blue;
  logic [0:0][9:0]    rom_addr2;
  logic [0:0][3:0]    rom_q2;
  logic [3:0]         red2, green2, blue2;

  assign rom_q2 = 4'd3;

  sprite_layer #(.NUM_SPRITES(NS), .BG_RGB(BG)) u_dut (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .ld(bus), .rom_addr(rom_addr), .rom_q(rom_q),
    .red(red), .green(green), .blue(blue)
  );

  sprite_layer #(.NUM_SPRITES(1), .SCALE_SHIFT(1), .BG_RGB(BG)) u_dut2 (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .ld(bus2), .rom_addr(rom_addr2), .rom_q(rom_q2),
    .red(red2), .green(green2), .blue(blue2)
  );

  logic [3:0] rom_mem [NS][1024];
  always @(posedge clk)
    for (int s = 0; s < NS; s++) rom_q[s] <= rom_mem[s][rom_addr[s]];

  rgb12_t pal [16] = '{12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF,
                       12'h888, 12'h800, 12'h080, 12'h008, 12'h880, 12'h088, 12'h808, 12'h444};

  typedef struct { bit chk; rgb12_t rgb; rgb12_t rgb2; int id; } exp_t;
  exp_t sbq [$];

  sprite_pos_t m_act [NS], m_shd [NS];
  bit          m_pend [NS];
  sprite_pos_t m2_act, m2_shd;
  bit          m2_pend;

  bit  lv, lv2, len, len2;
  int  lid, lx, ly, lx2, ly2;
  int  pix_n;
  bit  a2_pend;
  logic [9:0] a2_exp;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic rgb12_t exp_px(input int x, input int y, input bit b);
    if (!b) return 12'h000;
    for (int s = 0; s < NS; s++) begin
      int dx = x - int'(m_act[s].x);
      int dy = y - int'(m_act[s].y);
      if (m_act[s].en && dx >= 0 && dy >= 0 && dx < 32 && dy < 32 && x < 640 && y < 480) begin
        logic [3:0] idx;
        idx = rom_mem[s][dy*32 + dx];
        if (idx != 4'd0) return pal[idx];
      end
    end
    return BG;
  endfunction

  function automatic rgb12_t exp_px2(input int x, input int y, input bit b);
    int dx = x - int'(m2_act.x);
    int dy = y - int'(m2_act.y);
    if (!b) return 12'h000;
    if (m2_act.en && dx >= 0 && dy >= 0 && dx < 64 && dy < 64 && x < 640 && y < 480)
      return pal[3];
    return BG;
  endfunction

  task automatic step(input int x, input int y, input bit b, input bit ck = 1'b1, input bit rel = 1'b0);
    exp_t e;
    bit   rdy;
    @(negedge clk);
    e = sbq.pop_front();
    if (e.chk) begin
      chk($sformatf("rgb#%0d", e.id), {20'd0, red, green, blue}, {20'd0, e.rgb});
      chk($sformatf("rgb2#%0d", e.id), {20'd0, red2, green2, blue2}, {20'd0, e.rgb2});
    end
    if (a2_pend) chk($sformatf("addr2#%0d", pix_n-1), {22'd0, rom_addr2[0]}, {22'd0, a2_exp});
    if (rel) reset_n = 1'b1;
    DrawX = 10'(x); DrawY = 10'(y); blank = b;
    bus.load_valid  = lv;  bus.load_id  = 2'(lid); bus.load_x  = 10'(lx);
    bus.load_y      = 10'(ly); bus.load_en = len;
    bus2.load_valid = lv2; bus2.load_id = 2'd0; bus2.load_x = 10'(lx2);
    bus2.load_y     = 10'(ly2); bus2.load_en = len2;
    rdy = !(x == 0 && y == 480);
    #1;
    chk($sformatf("ready#%0d", pix_n), {31'd0, bus.load_ready}, {31'd0, rdy});
    e.chk = ck; e.rgb = exp_px(x, y, b); e.rgb2 = exp_px2(x, y, b); e.id = pix_n;
    sbq.push_back(e);
    pix_n++;
    a2_exp  = {5'(y >> 1), 5'(x >> 1)};
    a2_pend = 1'b1;
    if (!rdy) begin
      for (int s = 0; s < NS; s++)
        if (m_pend[s]) begin m_act[s] = m_shd[s]; m_pend[s] = 1'b0; end
      if (m2_pend) begin m2_act = m2_shd; m2_pend = 1'b0; end
    end
    if (lv && rdy) begin
      if (lid < NS) begin
        m_shd[lid].x = 10'(lx); m_shd[lid].y = 10'(ly); m_shd[lid].en = len;
        m_pend[lid] = 1'b1;
      end
      lv = 1'b0;
    end
    if (lv2 && rdy) begin
      m2_shd.x = 10'(lx2); m2_shd.y = 10'(ly2); m2_shd.en = len2;
      m2_pend = 1'b1;
      lv2 = 1'b0;
    end
  endtask

  task automatic do_reset(input int cycles);
    exp_t z;
    reset_n = 1'b0;
    blank   = 1'b0;
    #1;
    chk("rst_rgb",   {20'd0, red, green, blue},    32'd0);
    chk("rst_rgb2",  {20'd0, red2, green2, blue2}, 32'd0);
    chk("rst_ready", {31'd0, bus.load_ready},      32'd1);
    sbq.delete();
    z.chk = 1'b1; z.rgb = 12'h000; z.rgb2 = 12'h000; z.id = -1;
    repeat (3) sbq.push_back(z);
    a2_pend = 1'b0;
    for (int s = 0; s < NS; s++) begin m_act[s] = '0; m_shd[s] = '0; m_pend[s] = 1'b0; end
    m2_act = '0; m2_shd = '0; m2_pend = 1'b0;
    lv = 1'b0; lv2 = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic load0(input int id, input int x, input int y, input bit en);
    lv = 1'b1; lid = id; lx = x; ly = y; len = en;
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin
      rom_mem[0][a] = (a == 0) ? 4'd3 : 4'((a % 7) + 1);
      rom_mem[1][a] = 4'((a % 5) + 8);
    end
    rom_mem[0][33] = 4'd0;
    bus.load_valid = 1'b0; bus.load_id = '0; bus.load_x = '0; bus.load_y = '0; bus.load_en = 1'b0;
    bus2.load_valid = 1'b0; bus2.load_id = '0; bus2.load_x = '0; bus2.load_y = '0; bus2.load_en = 1'b0;
    lid = 0; lx = 0; ly = 0; len = 1'b0; lx2 = 0; ly2 = 0; len2 = 1'b0;
    pix_n = 0;
    #2;
    do_reset(3);

    // Load presented in the release cycle must land.
    load0(0, 100, 50, 1'b1);
    lv2 = 1'b1; lx2 = 0; ly2 = 0; len2 = 1'b1;
    step(100, 50, 1'b1, 1'b1, 1'b1);
    step(100, 50, 1'b1); step(0, 0, 1'b1);
    step(0, 480, 1'b0);
    step(100, 50, 1'b1); step(99, 50, 1'b1); step(101, 50, 1'b1); step(100, 51, 1'b1);
    step(131, 50, 1'b1); step(132, 50, 1'b1); step(100, 50, 1'b0);

    // Scaled instance: address steps every second column, edge at 64.
    step(0, 0, 1'b1); step(1, 0, 1'b1); step(2, 0, 1'b1); step(3, 0, 1'b1);
    step(63, 5, 1'b1); step(64, 5, 1'b1); step(0, 64, 1'b1);

    // Overlap priority and transparency; id 3 is discarded.
    load0(0, 200, 200, 1'b1); step(0, 10, 1'b1);
    load0(1, 200, 200, 1'b1); step(0, 11, 1'b1);
    load0(3, 100, 50, 1'b1);  step(0, 12, 1'b1);
    step(0, 480, 1'b0);
    step(200, 200, 1'b1); step(201, 201, 1'b1); step(202, 201, 1'b1);
    step(100, 50, 1'b1); step(231, 231, 1'b1); step(232, 231, 1'b1);

    // Mid-frame reloads keep the old position until the next commit.
    step(5, 100, 1'b1);
    load0(0, 10, 100, 1'b1); step(6, 100, 1'b1);
    step(200, 205, 1'b1);
    load0(0, 20, 100, 1'b1); step(7, 150, 1'b1);
    step(20, 105, 1'b1); step(200, 205, 1'b1);
    load0(1, 0, 0, 1'b0);    step(0, 480, 1'b0);
    step(1, 480, 1'b0);
    step(20, 100, 1'b1); step(10, 100, 1'b1); step(200, 200, 1'b1);
    step(0, 480, 1'b0);
    step(200, 200, 1'b1);

    // Right-edge clip, no wrap, blank forcing zero.
    load0(0, 620, 240, 1'b1); step(0, 1, 1'b1);
    step(0, 480, 1'b0);
    step(620, 240, 1'b1); step(639, 240, 1'b1); step(0, 240, 1'b1); step(11, 240, 1'b1);
    step(640, 240, 1'b0); step(630, 241, 1'b0); step(630, 241, 1'b1);

    // Reset mid-frame clears everything until reloaded.
    do_reset(2);
    step(620, 240, 1'b1, 1'b1, 1'b1);
    step(0, 480, 1'b0);
    step(620, 240, 1'b1); step(630, 241, 1'b1);
    load0(0, 620, 240, 1'b1); step(0, 2, 1'b1);
    step(0, 480, 1'b0);
    step(620, 240, 1'b1); step(625, 245, 1'b1);
    repeat (3) step(0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
